// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - tagged-transaction memory responder with per-tag load snapshots and jittered latency
module mem_responder #(
  parameter int NUM_MEM_TAGS = 15,
  parameter int MEM_LATENCY  = 4,
  parameter int JITTER_BITS  = 0,
  parameter int MEM_DEPTH    = 64,
  parameter int ADDR_WIDTH   = 32,
  localparam int TAG_W = $clog2(NUM_MEM_TAGS + 1),
  localparam int IDX_W = $clog2(MEM_DEPTH),
  localparam int CNT_W = $clog2(MEM_LATENCY + (1 << JITTER_BITS)) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_en,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [63:0]           mem_wdata,
  output logic [TAG_W-1:0]      mem_transaction_tag,
  output logic [TAG_W-1:0]      mem_data_tag,
  output logic [63:0]           mem_data,
  output logic [TAG_W-1:0]      outstanding
);

  logic [NUM_MEM_TAGS:1] busy;
  logic [CNT_W-1:0]      cnt  [1:NUM_MEM_TAGS];
  logic [63:0]           snap [1:NUM_MEM_TAGS];
  logic [63:0]           mem  [MEM_DEPTH];
  logic [7:0]            lfsr;
  logic [7:0]            jit_mask;
  logic [TAG_W-1:0]      free_tag;
  logic [TAG_W-1:0]      due_tag;
  logic [CNT_W-1:0]      lat_m2;
  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic                  addr_unused;

  assign idx         = mem_addr[3 +: IDX_W];
  assign addr_unused = ^mem_addr;
  assign accept      = mem_en && (free_tag != '0);
  assign jit_mask    = 8'((9'd1 << JITTER_BITS) - 9'd1);
  // Countdown holds L-2 so the entry is due in cycle t+L-1 and its response registers into cycle t+L.
  assign lat_m2      = CNT_W'(MEM_LATENCY - 2) + CNT_W'(lfsr & jit_mask);

  assign mem_transaction_tag = free_tag;

  always_comb begin
    free_tag = '0;
    due_tag  = '0;
    for (int i = NUM_MEM_TAGS; i >= 1; i--) begin
      if (!busy[i]) free_tag = TAG_W'(i);
      if (busy[i] && (cnt[i] == '0)) due_tag = TAG_W'(i);
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 1; i <= NUM_MEM_TAGS; i++) begin
      if (busy[i]) outstanding = outstanding + TAG_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy         <= '0;
      mem_data_tag <= '0;
      mem_data     <= '0;
      lfsr         <= 8'h01;
      for (int i = 1; i <= NUM_MEM_TAGS; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      // Due entries saturate at zero and stay due until they win selection.
      for (int i = 1; i <= NUM_MEM_TAGS; i++) begin
        if (busy[i] && (cnt[i] != '0)) cnt[i] <= cnt[i] - CNT_W'(1);
      end
      mem_data_tag <= due_tag;
      mem_data     <= (due_tag != '0) ? snap[due_tag] : '0;
      if (due_tag != '0) busy[due_tag] <= 1'b0;
      if (accept && !mem_wr) begin
        busy[free_tag] <= 1'b1;
        cnt[free_tag]  <= lat_m2;
        snap[free_tag] <= mem[idx];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (accept && mem_wr) begin
      mem[idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vectors, corner sequences and scoreboard soak for mem_responder
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        en, wr;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  t0, dt0, o0, t1, dt1, o1, t2, dt2, o2;
  logic [63:0] d0, d1, d2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_responder #(.MEM_LATENCY(4)) u0 (
    .clock(clock), .reset(rst_n), .mem_en(en), .mem_wr(wr), .mem_addr(addr), .mem_wdata(wdata),
    .mem_transaction_tag(t0), .mem_data_tag(dt0), .mem_data(d0), .outstanding(o0));

  mem_responder #(.MEM_LATENCY(20)) u1 (
    .clock(clock), .reset(rst_n), .mem_en(en), .mem_wr(wr), .mem_addr(addr), .mem_wdata(wdata),
    .mem_transaction_tag(t1), .mem_data_tag(dt1), .mem_data(d1), .outstanding(o1));

  mem_responder #(.MEM_LATENCY(4), .JITTER_BITS(2)) u2 (
    .clock(clock), .reset(rst_n), .mem_en(en), .mem_wr(wr), .mem_addr(addr), .mem_wdata(wdata),
    .mem_transaction_tag(t2), .mem_data_tag(dt2), .mem_data(d2), .outstanding(o2));

  typedef struct {
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  tt;
    logic [3:0]  dt;
    logic [63:0] data;
    logic [3:0]  outs;
  } vec_t;

  vec_t        tbl [15];
  logic [63:0] model [64];
  logic        pend [1:15];
  logic [63:0] expd [1:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [31:0] a, input logic [63:0] d);
    en = e; wr = w; addr = a; wdata = d;
  endtask

  // Leaves the bench in cycle 0: reset released just after an edge, LFSR still 8'h01.
  task automatic reset_dut();
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int np;
    logic [3:0] efree;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 64'h0);

    // store/load, tag reuse, snapshot ordering and aliasing on u0 (L=4, no jitter)
    tbl[0]  = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd1, 4'd0, 64'h0,                   4'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'h040, 64'hDEADBEEF_CAFEF00D,   4'd1, 4'd0, 64'h0,                   4'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'h040, 64'h0,                   4'd1, 4'd0, 64'h0,                   4'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd2, 4'd0, 64'h0,                   4'd1};
    tbl[4]  = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd2, 4'd0, 64'h0,                   4'd1};
    tbl[5]  = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd2, 4'd0, 64'h0,                   4'd1};
    tbl[6]  = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd1, 4'd1, 64'hDEADBEEF_CAFEF00D,   4'd0};
    tbl[7]  = '{1'b1, 1'b0, 32'h008, 64'h0,                   4'd1, 4'd0, 64'h0,                   4'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'h208, 64'h1,                   4'd2, 4'd0, 64'h0,                   4'd1};
    tbl[9]  = '{1'b1, 1'b0, 32'h008, 64'h0,                   4'd2, 4'd0, 64'h0,                   4'd1};
    tbl[10] = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd3, 4'd0, 64'h0,                   4'd2};
    tbl[11] = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd1, 4'd1, 64'h0,                   4'd1};
    tbl[12] = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd1, 4'd0, 64'h0,                   4'd1};
    tbl[13] = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd1, 4'd2, 64'h1,                   4'd0};
    tbl[14] = '{1'b0, 1'b0, 32'h000, 64'h0,                   4'd1, 4'd0, 64'h0,                   4'd0};

    reset_dut();
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("tbl%0d_ttag", k), t0,  tbl[k].tt);
      chk($sformatf("tbl%0d_dtag", k), dt0, tbl[k].dt);
      chk($sformatf("tbl%0d_data", k), d0,  tbl[k].data);
      chk($sformatf("tbl%0d_outs", k), o0,  tbl[k].outs);
      drive(tbl[k].en, tbl[k].wr, tbl[k].addr, tbl[k].wdata);
      step();
    end

    // reset mid-traffic with a response visible and 3 loads outstanding
    reset_dut();
    drive(1'b1, 1'b1, 32'h20, 64'h55);
    step();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 32'h20, 64'h0);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    chk("rst_pre_dtag", dt0, 64'd1);
    chk("rst_pre_data", d0,  64'h55);
    chk("rst_pre_outs", o0,  64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ttag", t0,  64'd1);
    chk("rst_dtag", dt0, 64'd0);
    chk("rst_data", d0,  64'd0);
    chk("rst_outs", o0,  64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst_quiet%0d_dtag", k), dt0, 64'd0);
      chk($sformatf("rst_quiet%0d_outs", k), o0,  64'd0);
      step();
    end
    chk("rst_reload_ttag", t0, 64'd1);
    drive(1'b1, 1'b0, 32'h20, 64'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    repeat (3) step();
    chk("rst_reload_dtag", dt0, 64'd1);
    chk("rst_reload_data", d0,  64'd0);

    // tag exhaustion on u1 (L=20)
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("exh%0d_ttag", k), t1, (k < 15) ? 64'(k + 1) : 64'd0);
      if (k == 15) chk("exh15_outs", o1, 64'd15);
      drive(1'b1, 1'b0, 32'(k * 8), 64'h0);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    for (int k = 16; k < 20; k++) begin
      chk($sformatf("exh%0d_ttag", k), t1,  64'd0);
      chk($sformatf("exh%0d_dtag", k), dt1, 64'd0);
      step();
    end
    chk("exh20_dtag", dt1, 64'd1);
    chk("exh20_ttag", t1,  64'd1);
    chk("exh20_outs", o1,  64'd14);
    step();
    for (int k = 21; k < 35; k++) begin
      chk($sformatf("exh%0d_dtag", k), dt1, 64'(k - 19));
      step();
    end
    for (int k = 35; k < 41; k++) begin
      chk($sformatf("exh%0d_dtag", k), dt1, 64'd0);
      chk($sformatf("exh%0d_outs", k), o1,  64'd0);
      step();
    end

    // contention on u2: LFSR 01,02,04,08 gives L=6 for cycle 1 and L=4 for cycle 3, both due in cycle 6
    reset_dut();
    drive(1'b1, 1'b1, 32'h10, 64'hAAAA);
    step();
    chk("con_ttag1", t2, 64'd1);
    drive(1'b1, 1'b0, 32'h10, 64'h0);
    step();
    drive(1'b1, 1'b1, 32'h18, 64'hBBBB);
    step();
    chk("con_ttag2", t2, 64'd2);
    drive(1'b1, 1'b0, 32'h18, 64'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    for (int k = 4; k < 7; k++) begin
      chk($sformatf("con%0d_dtag", k), dt2, 64'd0);
      step();
    end
    chk("con7_dtag", dt2, 64'd1);
    chk("con7_data", d2,  64'hAAAA);
    chk("con7_outs", o2,  64'd1);
    step();
    chk("con8_dtag", dt2, 64'd2);
    chk("con8_data", d2,  64'hBBBB);
    chk("con8_outs", o2,  64'd0);
    step();
    chk("con9_dtag", dt2, 64'd0);

    // random soak against a scoreboard on u1
    for (int i = 0; i < 64; i++) model[i] = 64'h0;
    for (int i = 1; i <= 15; i++) begin
      pend[i] = 1'b0;
      expd[i] = 64'h0;
    end
    reset_dut();
    for (int cyc = 0; cyc < 10060; cyc++) begin
      if (dt1 != 4'd0) begin
        chk("soak_resp_pending", 64'(pend[dt1]), 64'd1);
        chk("soak_resp_data", d1, expd[dt1]);
        pend[dt1] = 1'b0;
      end else begin
        chk("soak_idle_data", d1, 64'd0);
      end
      np = 0;
      efree = 4'd0;
      for (int i = 15; i >= 1; i--) begin
        if (pend[i]) np++;
        else efree = 4'(i);
      end
      chk("soak_outs", o1, 64'(np));
      chk("soak_ttag", t1, 64'(efree));
      if (cyc < 10000) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
              32'($urandom_range(0, 4095)), {$urandom, $urandom});
      end else begin
        drive(1'b0, 1'b0, 32'h0, 64'h0);
      end
      if (en && (efree != 4'd0)) begin
        if (wr) begin
          model[addr[8:3]] = wdata;
        end else begin
          pend[efree] = 1'b1;
          expd[efree] = model[addr[8:3]];
        end
      end
      step();
    end
    np = 0;
    for (int i = 1; i <= 15; i++) if (pend[i]) np++;
    chk("soak_drained", 64'(np), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
